// File: rtl/one_port_ram_pkg.sv
// Shared definitions for one_port_ram_async: default geometry, word type and
// the even-parity helper used when ONE_PORT_RAM_PARITY_EN is defined.
package one_port_ram_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 1;
  localparam int unsigned DEPTH          = 2 ** DEF_ADDR_WIDTH;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

  // Even parity: the returned bit makes ^{word, parity} equal to 0.
  function automatic logic par_f(input word_t w);
    return ^w;
  endfunction

endpackage : one_port_ram_pkg

// File: rtl/one_port_ram_wr_decode.sv
// Write-address decoder for one_port_ram_async.
// Turns addr + we into a one-hot per-word write-enable vector.
// Ports:
//   we       in   write enable (X/Z decodes to no write)
//   addr     in   ADDR_WIDTH word address
//   wr_en_c  out  2**ADDR_WIDTH one-hot write enables (combinational)
module one_port_ram_wr_decode
  import one_port_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        addr,
  output logic [(2**ADDR_WIDTH)-1:0]   wr_en_c
);

  // if() takes the false branch on X/Z, so an unknown we never writes.
  always_comb begin
    wr_en_c = '0;
    if (we) begin
      wr_en_c[addr] = 1'b1;
    end
  end

endmodule : one_port_ram_wr_decode

// File: rtl/one_port_ram_async.sv
// Single-port register-file RAM: synchronous write, combinational read.
// Storage is flops so the whole array clears on asynchronous reset.
// Optional feature macro: ONE_PORT_RAM_PARITY_EN (adds per-word even parity
// and the combinational parity_err output).
// Ports:
//   clk         in   write clock (rising edge)
//   rst_n       in   asynchronous active-low reset, clears every word
//   we          in   write enable
//   addr        in   shared read/write address
//   din         in   write data
//   dout        out  mem[addr], combinational
//   parity_err  out  ^{mem[addr], parity[addr]} (parity build only)
module one_port_ram_async
  import one_port_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
`ifdef ONE_PORT_RAM_PARITY_EN
  output logic                  parity_err,
`endif
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned MEM_DEPTH = 2 ** ADDR_WIDTH;

  logic [MEM_DEPTH-1:0]  wr_en;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  one_port_ram_wr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_decode (
    .we      (we),
    .addr    (addr),
    .wr_en_c (wr_en)
  );

  // Next-state of the storage array: only the decoded word takes din.
  always_comb begin
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en[i]) begin
        mem_d[i] = din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Zero-latency read port.
  assign dout = mem_q[addr];

`ifdef ONE_PORT_RAM_PARITY_EN
  logic par_q [MEM_DEPTH];
  logic par_d [MEM_DEPTH];

  // Parity bit is captured alongside the data, computed from din.
  always_comb begin
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      par_d[i] = par_q[i];
      if (wr_en[i]) begin
        par_d[i] = par_f(word_t'(din));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        par_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        par_q[i] <= par_d[i];
      end
    end
  end

  assign parity_err = ^{mem_q[addr], par_q[addr]};
`endif

`ifndef SYNTHESIS
  // Unknown write enable is dropped by the decoder; make it visible in sim.
  always_ff @(posedge clk) begin
    if (rst_n && $isunknown(we)) begin
      $warning("one_port_ram_async: we is X/Z at write edge, write dropped");
    end
  end
`endif

endmodule : one_port_ram_async

// File: tb/tb_one_port_ram_async.sv
// Directed self-checking bench for one_port_ram_async (default 256 x 1).
module tb_one_port_ram_async;

  localparam int unsigned AW = 8;
  localparam int unsigned NW = 2 ** AW;

  logic          clk;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] addr;
  logic [0:0]    din;
  logic [0:0]    dout;
`ifdef ONE_PORT_RAM_PARITY_EN
  logic          parity_err;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        exp_mem [NW];

  one_port_ram_async #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .addr       (addr),
    .din        (din),
`ifdef ONE_PORT_RAM_PARITY_EN
    .parity_err (parity_err),
`endif
    .dout       (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive addr, let the combinational read settle, compare dout (and parity).
  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic e);
    addr = a;
    #1;
    check_eq($sformatf("%s@%02h", tag, a), 32'(dout), 32'(e));
`ifdef ONE_PORT_RAM_PARITY_EN
    check_eq($sformatf("%s_par@%02h", tag, a), 32'(parity_err), 32'd0);
`endif
  endtask

  // One write cycle, set up after a falling edge, we dropped after the rise.
  task automatic wr(input logic [AW-1:0] a, input logic d);
    @(negedge clk);
    we = 1'b1; addr = a; din = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic sweep_model(input string tag);
    for (int i = 0; i < int'(NW); i++) begin
      rd_chk(tag, AW'(i), exp_mem[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; addr = '0; din = '0;
    for (int i = 0; i < int'(NW); i++) exp_mem[i] = 1'b0;

    // Reset held for 3 clocks; every word reads 0 while rst_n is low.
    repeat (3) @(posedge clk);
    #1;
    sweep_model("rst_sweep");

    // Write attempted during reset is ignored.
    @(negedge clk);
    we = 1'b1; addr = 8'h20; din = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    rd_chk("wr_in_rst", 8'h20, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // Low end and high end writes.
    wr(8'h00, 1'b0);
    rd_chk("low_end", 8'h00, 1'b0);
    wr(8'hFF, 1'b1);
    rd_chk("high_end", 8'hFF, 1'b1);
    rd_chk("low_keep", 8'h00, 1'b0);

    // Async read: addr toggles between edges, dout follows immediately.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rd_chk("async_ff", 8'hFF, 1'b1);
      rd_chk("async_00", 8'h00, 1'b0);
    end

    // we=0 with din=1 over 5 edges: no write.
    @(negedge clk);
    we = 1'b0; addr = 8'h10; din = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rd_chk("no_we", 8'h10, 1'b0);

    // Read-during-write: old value before the edge, din after it.
    @(negedge clk);
    we = 1'b1; addr = 8'h40; din = 1'b1;
    #1;
    check_eq("rdw_before", 32'(dout), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rdw_after", 32'(dout), 32'd1);
    we = 1'b0;
    exp_mem[8'h40] = 1'b1;

    // Decode isolation and overwrite.
    wr(8'h55, 1'b1);
    rd_chk("iso_55", 8'h55, 1'b1);
    rd_chk("iso_54", 8'h54, 1'b0);
    rd_chk("iso_56", 8'h56, 1'b0);
    wr(8'h80, 1'b1);
    wr(8'h01, 1'b1);
    rd_chk("set_80", 8'h80, 1'b1);
    wr(8'h80, 1'b0);
    rd_chk("ovw_80", 8'h80, 1'b0);
    sweep_model("model_sweep");

    // Async reset mid-cycle: FF drops to 0 without a clock edge.
    @(negedge clk);
    addr = 8'hFF;
    #1;
    check_eq("pre_rst_ff", 32'(dout), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_ff", 32'(dout), 32'd0);
    for (int i = 0; i < int'(NW); i++) exp_mem[i] = 1'b0;

    // Write attempted with reset still asserted leaves the word at 0.
    we = 1'b1; addr = 8'h30; din = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    rd_chk("rst_mid_wr", 8'h30, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_model("post_rst_sweep");

    // RAM still writable after reset release.
    wr(8'hFF, 1'b1);
    rd_chk("post_rst_wr", 8'hFF, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_one_port_ram_async
